expr_eval_ctrl: RTL and testbench

- Streaming evaluator and sequencer for single-digit ASCII arithmetic expressions over '+' and '*'; '*' binds tighter than '+'.
- Accepts one character per handshake, checks syntax with an FSM and accumulates the value on the fly.
- Presents the result, or an error flag, behind an output handshake.
- Sits between a character source (UART or test driver) and downstream consumers, as the control layer over the expression recogniser datapath.

---
 rtl/expr_pkg.sv | 24 ++
 rtl/expr_eval_ctrl_if.sv | 38 +++
 rtl/expr_char_class.sv | 30 +++
 rtl/expr_eval_ctrl.sv | 126 ++++++++++++
 tb/tb_expr_eval_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/expr_pkg.sv
// Shared constants and encodings for the streaming expression evaluator.
// Characters, FSM states and character classes live here.
package expr_pkg;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_TIMES = 8'h2A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;

  localparam logic [1:0] S_EXP_D = 2'd0;
  localparam logic [1:0] S_EXP_O = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [2:0] {
    C_DIGIT,
    C_PLUS,
    C_TIMES,
    C_EQ,
    C_OTHER
  } cls_e;

endpackage

// File: rtl/expr_eval_ctrl_if.sv
// Character-in / result-out handshake bundle of the expression evaluator.
// The evaluator is the slave; the character source and consumer form the master.
interface expr_eval_ctrl_if #(
  parameter int W = 16
);

  logic         in_valid;
  logic [7:0]   in_char;
  logic         in_ready;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res;
  logic         err;
  logic         busy;

  modport master (
    output in_valid,
    output in_char,
    output res_ready,
    input  in_ready,
    input  res_valid,
    input  res,
    input  err,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_char,
    input  res_ready,
    output in_ready,
    output res_valid,
    output res,
    output err,
    output busy
  );

endinterface

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier: maps a character to its class
// and, for digits, to the numeric value 0..9.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch_i,
  output cls_e       cls_o,
  output logic [3:0] dig_o
);

  logic [7:0] off;

  assign off = ch_i - CH_ZERO;

  always_comb begin
    cls_o = C_OTHER;
    dig_o = 4'd0;
    unique case (1'b1)
      (ch_i >= CH_ZERO && ch_i <= CH_NINE): begin
        cls_o = C_DIGIT;
        dig_o = off[3:0];
      end
      (ch_i == CH_PLUS):  cls_o = C_PLUS;
      (ch_i == CH_TIMES): cls_o = C_TIMES;
      (ch_i == CH_EQ):    cls_o = C_EQ;
      default:            cls_o = C_OTHER;
    endcase
  end

endmodule

// File: rtl/expr_eval_ctrl.sv
// Streaming evaluator for single-digit '+'/'*' expressions terminated by '='.
// S holds the sum of finished terms, P the product of the open term.
module expr_eval_ctrl
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input logic              clk,
  input logic              clr,
  expr_eval_ctrl_if.slave  bus
);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] s_q, s_d;
  logic [W-1:0] p_q, p_d;
  logic [W-1:0] res_q, res_d;
  logic         vld_q, vld_d;
  logic         err_q, err_d;
  logic         busy_q, busy_d;

  cls_e         cls;
  logic [3:0]   dig;
  logic         acc;
  logic         hs;
  logic [W-1:0] sum;
  logic [W-1:0] prod;

  expr_char_class u_cls (
    .ch_i  (bus.in_char),
    .cls_o (cls),
    .dig_o (dig)
  );

  assign bus.in_ready  = (state_q != S_DONE);
  assign bus.res_valid = vld_q;
  assign bus.res       = res_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

  assign acc  = bus.in_valid && bus.in_ready;
  assign hs   = vld_q && bus.res_ready;
  assign sum  = s_q + p_q;
  assign prod = p_q * W'(dig);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    p_d     = p_q;
    res_d   = res_q;
    vld_d   = vld_q;
    err_d   = err_q;
    busy_d  = busy_q;
    if (acc) begin
      busy_d = 1'b1;
      unique case (state_q)
        S_EXP_D: begin
          if (cls == C_DIGIT) begin
            p_d     = prod;
            state_d = S_EXP_O;
          end else if (cls == C_EQ) begin
            res_d   = '0;
            err_d   = 1'b1;
            vld_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_EXP_O: begin
          unique case (cls)
            C_PLUS: begin
              s_d     = sum;
              p_d     = W'(1);
              state_d = S_EXP_D;
            end
            C_TIMES: state_d = S_EXP_D;
            C_EQ: begin
              res_d   = sum;
              err_d   = 1'b0;
              vld_d   = 1'b1;
              state_d = S_DONE;
            end
            default: state_d = S_ERR;
          endcase
        end
        S_ERR: begin
          if (cls == C_EQ) begin
            res_d   = '0;
            err_d   = 1'b1;
            vld_d   = 1'b1;
            state_d = S_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (state_q == S_DONE && hs) begin
      // result taken: start a fresh expression next cycle
      vld_d   = 1'b0;
      s_d     = '0;
      p_d     = W'(1);
      busy_d  = 1'b0;
      state_d = S_EXP_D;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_EXP_D;
      s_q     <= '0;
      p_q     <= W'(1);
      res_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      p_q     <= p_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Directed bench for expr_eval_ctrl: 16-bit and 8-bit instances,
// character streams with hand-computed results.
module tb_expr_eval_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       res_ready = 1'b0;
  logic       sel8 = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [15:0] got_res[$];
  logic        got_err[$];
  int          rlow;
  int          vcyc;
  int          unstable;

  always #5 clk = ~clk;

  expr_eval_ctrl_if #(.W(16)) b16 ();
  expr_eval_ctrl_if #(.W(8))  b8 ();

  expr_eval_ctrl #(.W(16)) dut16 (
    .clk (clk),
    .clr (clr),
    .bus (b16.slave)
  );

  expr_eval_ctrl #(.W(8)) dut8 (
    .clk (clk),
    .clr (clr),
    .bus (b8.slave)
  );

  assign b16.in_valid  = in_valid && !sel8;
  assign b16.in_char   = in_char;
  assign b16.res_ready = res_ready;
  assign b8.in_valid   = in_valid && sel8;
  assign b8.in_char    = in_char;
  assign b8.res_ready  = res_ready;

  logic        o_ready, o_valid, o_err, o_busy;
  logic [15:0] o_res;

  assign o_ready = sel8 ? b8.in_ready  : b16.in_ready;
  assign o_valid = sel8 ? b8.res_valid : b16.res_valid;
  assign o_err   = sel8 ? b8.err       : b16.err;
  assign o_busy  = sel8 ? b8.busy      : b16.busy;
  assign o_res   = sel8 ? {8'h00, b8.res} : b16.res;

  task automatic stream(input string s, input int n_exp, input int hold);
    int i;
    int cyc;
    int hcnt;
    logic [15:0] fr;
    logic        fe;
    i = 0;
    cyc = 0;
    hcnt = 0;
    fr = '0;
    fe = 1'b0;
    got_res.delete();
    got_err.delete();
    rlow = 0;
    vcyc = 0;
    unstable = 0;
    while (got_res.size() < n_exp && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!o_ready) rlow++;
      if (o_valid) begin
        vcyc++;
        if (hcnt == 0) begin
          fr = o_res;
          fe = o_err;
        end else if (o_res !== fr || o_err !== fe) begin
          unstable++;
        end
        if (hcnt >= hold) begin
          res_ready = 1'b1;
          got_res.push_back(o_res);
          got_err.push_back(o_err);
          hcnt = 0;
        end else begin
          res_ready = 1'b0;
          hcnt++;
        end
      end else begin
        res_ready = 1'b0;
      end
      if (i < s.len()) begin
        in_valid = 1'b1;
        in_char  = s[i];
        if (o_ready) i++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (got_res.size() < n_exp) begin
      tests++;
      fails++;
      $display("FAIL timeout on \"%s\": got %0d results, required %0d",
               s, got_res.size(), n_exp);
    end
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (o_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset in_ready: got %b required 1", o_ready);
    end
    tests++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset res_valid: got %b required 0", o_valid);
    end
    tests++;
    if (o_res !== 16'd0) begin
      fails++;
      $display("FAIL reset res: got %0d required 0", o_res);
    end
    tests++;
    if (o_err !== 1'b0) begin
      fails++;
      $display("FAIL reset err: got %b required 0", o_err);
    end
    tests++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset busy: got %b required 0", o_busy);
    end
    clr = 1'b0;
  endtask

  task automatic test_precedence();
    stream("1+2*3=", 1, 0);
    tests++;
    if (got_res[0] !== 16'd7) begin
      fails++;
      $display("FAIL prec res: got %0d required 7", got_res[0]);
    end
    tests++;
    if (got_err[0] !== 1'b0) begin
      fails++;
      $display("FAIL prec err: got %b required 0", got_err[0]);
    end
    tests++;
    if (vcyc != 1) begin
      fails++;
      $display("FAIL prec valid_cycles: got %0d required 1", vcyc);
    end
    tests++;
    if (rlow != 1) begin
      fails++;
      $display("FAIL prec ready_low: got %0d required 1", rlow);
    end
    tests++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
      fails++;
      $display("FAIL prec idle: got busy=%b ready=%b required 0/1",
               o_busy, o_ready);
    end
  endtask

  task automatic test_back_to_back();
    stream("2*3*4+5=0*9+8=", 2, 0);
    tests++;
    if (got_res[0] !== 16'd29) begin
      fails++;
      $display("FAIL b2b res0: got %0d required 29", got_res[0]);
    end
    tests++;
    if (got_res[1] !== 16'd8) begin
      fails++;
      $display("FAIL b2b res1: got %0d required 8", got_res[1]);
    end
    tests++;
    if (got_err[0] !== 1'b0 || got_err[1] !== 1'b0) begin
      fails++;
      $display("FAIL b2b err: got %b%b required 00", got_err[0], got_err[1]);
    end
    tests++;
    if (rlow != 2) begin
      fails++;
      $display("FAIL b2b ready_low: got %0d required 2", rlow);
    end
  endtask

  task automatic test_errors();
    stream("1++2=12+1==", 3, 0);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (got_err[k] !== 1'b1) begin
        fails++;
        $display("FAIL err flag %0d: got %b required 1", k, got_err[k]);
      end
      tests++;
      if (got_res[k] !== 16'd0) begin
        fails++;
        $display("FAIL err res %0d: got %0d required 0", k, got_res[k]);
      end
    end
  endtask

  task automatic test_hold();
    stream("4*5=7=", 2, 5);
    tests++;
    if (got_res[0] !== 16'd20 || got_err[0] !== 1'b0) begin
      fails++;
      $display("FAIL hold res0: got %0d/%b required 20/0",
               got_res[0], got_err[0]);
    end
    tests++;
    if (got_res[1] !== 16'd7 || got_err[1] !== 1'b0) begin
      fails++;
      $display("FAIL hold res1: got %0d/%b required 7/0",
               got_res[1], got_err[1]);
    end
    tests++;
    if (unstable != 0) begin
      fails++;
      $display("FAIL hold stable: got %0d changes required 0", unstable);
    end
    tests++;
    if (rlow != 12) begin
      fails++;
      $display("FAIL hold ready_low: got %0d required 12", rlow);
    end
    tests++;
    if (vcyc != 12) begin
      fails++;
      $display("FAIL hold valid_cycles: got %0d required 12", vcyc);
    end
  endtask

  task automatic test_wrap8();
    sel8 = 1'b1;
    stream("9*9*9*9=", 1, 0);
    tests++;
    if (got_res[0] !== 16'd161 || got_err[0] !== 1'b0) begin
      fails++;
      $display("FAIL wrap8 prod: got %0d/%b required 161/0",
               got_res[0], got_err[0]);
    end
    stream("9*9*9+9*9*9+9*9*9+9*9*9=", 1, 0);
    tests++;
    if (got_res[0] !== 16'd100 || got_err[0] !== 1'b0) begin
      fails++;
      $display("FAIL wrap8 sum: got %0d/%b required 100/0",
               got_res[0], got_err[0]);
    end
    sel8 = 1'b0;
  endtask

  task automatic test_clr_async();
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = 8'h31;
    @(negedge clk);
    in_char  = 8'h2B;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (o_busy !== 1'b1) begin
      fails++;
      $display("FAIL clr pre busy: got %b required 1", o_busy);
    end
    #2 clr = 1'b1;
    #1;
    tests++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
      fails++;
      $display("FAIL clr ctl: got busy=%b ready=%b required 0/1",
               o_busy, o_ready);
    end
    tests++;
    if (o_valid !== 1'b0 || o_err !== 1'b0 || o_res !== 16'd0) begin
      fails++;
      $display("FAIL clr out: got v=%b e=%b r=%0d required 0/0/0",
               o_valid, o_err, o_res);
    end
    @(negedge clk);
    clr = 1'b0;
    stream("3=", 1, 0);
    tests++;
    if (got_res[0] !== 16'd3 || got_err[0] !== 1'b0) begin
      fails++;
      $display("FAIL clr after: got %0d/%b required 3/0",
               got_res[0], got_err[0]);
    end
  endtask

  initial begin
    test_reset();
    test_precedence();
    test_back_to_back();
    test_errors();
    test_hold();
    test_wrap8();
    test_clr_async();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
